// File: rtl/cp0_ctrl.sv
// MIPS CP0 register block: SR, Cause, EPC, PRID with mfc0/mtc0 port and interrupt request.
// Optional CP0_IP_LIVE_EN: IntReq samples live HWInt instead of registered Cause.IP.
module cp0_ctrl #(
  parameter logic [29:0] EPC_INIT = 30'h0000_0000,
  parameter logic [31:0] PRID     = 32'h0000_CD01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] PC,
  input  logic [31:0] Din,
  input  logic [5:0]  HWInt,
  input  logic [1:0]  Sel,
  input  logic        Wen,
  input  logic        EXLSet,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [29:0] EPC,
  output logic [31:0] DOut
);

  localparam logic [31:0] SR_RESET = 32'h0000_0001;

  logic [31:0] sr_q, sr_d;
  logic [5:0]  ip_q, ip_d;
  logic [29:0] epc_q, epc_d;
  logic [5:0]  ip_src;

  always_comb begin
    sr_d  = sr_q;
    epc_d = epc_q;
    ip_d  = HWInt;
    if (Wen && Sel == 2'd0) sr_d = Din;
    if (Wen && Sel == 2'd2) epc_d = Din[31:2];
    // Exception entry/return take priority over mtc0 only on EXL and EPC
    if (EXLSet) begin
      sr_d[1] = 1'b1;
      epc_d   = PC;
    end else if (EXLClr) begin
      sr_d[1] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q  <= SR_RESET;
      ip_q  <= '0;
      epc_q <= EPC_INIT;
    end else begin
      sr_q  <= sr_d;
      ip_q  <= ip_d;
      epc_q <= epc_d;
    end
  end

`ifdef CP0_IP_LIVE_EN
  assign ip_src = HWInt;
`else
  assign ip_src = ip_q;
`endif

  assign IntReq = (|(ip_src & sr_q[15:10])) & sr_q[0] & ~sr_q[1];
  assign EPC    = epc_q;

  always_comb begin
    DOut = '0;
    unique case (Sel)
      2'd0: DOut = sr_q;
      2'd1: DOut = {16'b0, ip_q, 10'b0};
      2'd2: DOut = {epc_q, 2'b00};
      2'd3: DOut = PRID;
      default: DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Self-checking bench for cp0_ctrl: directed scenarios plus random traffic against a register-level model.
`timescale 1ns/100ps
module tb_cp0_ctrl;

  localparam logic [29:0] EPC_RST = 30'h0ABC_0123;
  localparam logic [31:0] PRID_V  = 32'h0000_CD01;

  logic        clk = 1'b0;
  logic        reset;
  logic [29:0] PC;
  logic [31:0] Din;
  logic [5:0]  HWInt;
  logic [1:0]  Sel;
  logic        Wen, EXLSet, EXLClr;
  logic        IntReq;
  logic [29:0] EPC;
  logic [31:0] DOut;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference state
  logic [31:0] m_sr;
  logic [5:0]  m_ip;
  logic [29:0] m_epc;

  cp0_ctrl #(.EPC_INIT(EPC_RST), .PRID(PRID_V)) dut (
    .clk(clk), .reset(reset), .PC(PC), .Din(Din), .HWInt(HWInt), .Sel(Sel),
    .Wen(Wen), .EXLSet(EXLSet), .EXLClr(EXLClr),
    .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_sr  = 32'h0000_0001;
    m_ip  = 6'd0;
    m_epc = EPC_RST;
  endfunction

  function automatic void model_clock();
    if (Wen && Sel == 2'd0) m_sr = Din;
    if (EXLSet) begin
      m_sr[1] = 1'b1;
      m_epc   = PC;
    end else begin
      if (Wen && Sel == 2'd2) m_epc = Din[31:2];
      if (EXLClr) m_sr[1] = 1'b0;
    end
    m_ip = HWInt;
  endfunction

  function automatic logic model_int();
    logic [5:0] pend;
`ifdef CP0_IP_LIVE_EN
    pend = HWInt;
`else
    pend = m_ip;
`endif
    return ((pend & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
  endfunction

  task automatic check_all();
    logic [31:0] exp [4];
    exp[0] = m_sr;
    exp[1] = {16'b0, m_ip, 10'b0};
    exp[2] = {m_epc, 2'b00};
    exp[3] = PRID_V;
    for (int s = 0; s < 4; s++) begin
      Sel = 2'(s);
      #1;
      chk($sformatf("dout_sel%0d", s), DOut, exp[s]);
    end
    chk("epc", {2'b0, EPC}, {2'b0, m_epc});
    chk("intreq", {31'b0, IntReq}, {31'b0, model_int()});
  endtask

  task automatic step(input logic w, input logic [1:0] s, input logic [31:0] d,
                      input logic [5:0] h, input logic es, input logic ec, input logic [29:0] p);
    @(negedge clk);
    Wen = w; Sel = s; Din = d; HWInt = h; EXLSet = es; EXLClr = ec; PC = p;
    @(posedge clk);
    model_clock();
    #1;
    Wen = 1'b0; EXLSet = 1'b0; EXLClr = 1'b0;
    check_all();
  endtask

  initial begin
    reset = 1'b1; PC = '0; Din = '0; HWInt = '0; Sel = '0;
    Wen = 1'b0; EXLSet = 1'b0; EXLClr = 1'b0;
    model_reset();
    #25;
    check_all();
    chk("rst_prid", DOut, 32'h0000_CD01);
    @(negedge clk);
    reset = 1'b0;

    // mtc0 SR, then idle write data ignored
    step(1'b1, 2'd0, 32'h1234_5678, 6'd0, 1'b0, 1'b0, '0);
    chk("sr_write", m_sr, 32'h1234_5678);
    step(1'b0, 2'd0, 32'hFFFF_FFFF, 6'd0, 1'b0, 1'b0, '0);

    // exception entry and return from reset state
    @(negedge clk); reset = 1'b1; #2; model_reset(); @(negedge clk); reset = 1'b0;
    step(1'b0, 2'd0, '0, 6'd0, 1'b1, 1'b0, 30'h1234_5678);
    Sel = 2'd0; #1; chk("exl_set_sr", DOut, 32'h0000_0003);
    chk("exl_set_epc", {2'b0, EPC}, 32'h1234_5678);
    step(1'b0, 2'd0, '0, 6'd0, 1'b0, 1'b1, '0);
    Sel = 2'd0; #1; chk("exl_clr_sr", DOut, 32'h0000_0001);

    // interrupt masking / enabling
    step(1'b0, 2'd1, '0, 6'b101011, 1'b0, 1'b0, '0);
    Sel = 2'd1; #1; chk("cause_ac00", DOut, 32'h0000_AC00);
    step(1'b1, 2'd0, 32'h0000_5001, 6'b101011, 1'b0, 1'b0, '0);
    chk("int_masked", {31'b0, IntReq}, 32'd0);
    step(1'b0, 2'd0, '0, 6'b111011, 1'b0, 1'b0, '0);
    chk("int_on", {31'b0, IntReq}, 32'd1);
    step(1'b0, 2'd0, '0, 6'b111011, 1'b1, 1'b0, 30'h3478_ABCD);
    chk("int_exl", {31'b0, IntReq}, 32'd0);
    step(1'b0, 2'd0, '0, 6'b111011, 1'b0, 1'b1, '0);
    chk("int_eret", {31'b0, IntReq}, 32'd1);
    step(1'b1, 2'd0, 32'h0000_5000, 6'b111011, 1'b0, 1'b0, '0);
    chk("int_ie0", {31'b0, IntReq}, 32'd0);

    // same-cycle priority cases
    step(1'b1, 2'd0, 32'h0000_FC01, 6'b111111, 1'b1, 1'b0, 30'h0F0F_0F0F);
    step(1'b1, 2'd2, 32'hAAAA_5554, 6'd0, 1'b1, 1'b1, 30'h1111_2222);
    step(1'b1, 2'd0, 32'h0000_0003, 6'd0, 1'b0, 1'b1, '0);
    step(1'b1, 2'd2, 32'h8765_4321, 6'd0, 1'b0, 1'b0, '0);
    step(1'b1, 2'd1, 32'hFFFF_FFFF, 6'd5, 1'b0, 1'b0, '0);
    step(1'b1, 2'd3, 32'hFFFF_FFFF, 6'd5, 1'b0, 1'b0, '0);

    // random traffic with occasional mid-cycle asynchronous reset
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        @(negedge clk);
        Wen = 1'b1; Sel = 2'd0; Din = $urandom; EXLSet = 1'b1; PC = 30'($urandom);
        #3 reset = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        @(negedge clk);
        reset = 1'b0; Wen = 1'b0; EXLSet = 1'b0;
      end else begin
        step($urandom_range(0, 9) < 3, 2'($urandom), $urandom,
             ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom),
             $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0, 30'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
